// File: rtl/csr_access_arbiter_if.sv
// Requester and regfile signal bundle for csr_access_arbiter.
// The arbiter sits on the slave modport; the requesters and regfile model sit on the master modport.
interface csr_access_arbiter_if;
  // Each requester holds req (plus we/addr/wdata) until it sees gnt in the same cycle.
  // The response is a single-cycle rvalid pulse carrying rdata/exc.
  // On the regfile side, csr_req_o stays high until csr_ready_i completes the access.
  logic        core_req_i;
  logic        core_we_i;
  logic [11:0] core_addr_i;
  logic [63:0] core_wdata_i;
  logic        core_gnt_o;
  logic        core_rvalid_o;
  logic [63:0] core_rdata_o;
  logic        core_exc_valid_o;
  logic [63:0] core_exc_cause_o;

  logic        dbg_req_i;
  logic        dbg_we_i;
  logic [11:0] dbg_addr_i;
  logic [63:0] dbg_wdata_i;
  logic        dbg_gnt_o;
  logic        dbg_rvalid_o;
  logic [63:0] dbg_rdata_o;
  logic        dbg_exc_valid_o;
  logic [63:0] dbg_exc_cause_o;

  logic        csr_req_o;
  logic        csr_we_o;
  logic [11:0] csr_addr_o;
  logic [63:0] csr_wdata_o;
  logic [63:0] csr_rdata_i;
  logic        csr_ready_i;

  modport slave (
    input  core_req_i, core_we_i, core_addr_i, core_wdata_i,
    output core_gnt_o, core_rvalid_o, core_rdata_o, core_exc_valid_o, core_exc_cause_o,
    input  dbg_req_i, dbg_we_i, dbg_addr_i, dbg_wdata_i,
    output dbg_gnt_o, dbg_rvalid_o, dbg_rdata_o, dbg_exc_valid_o, dbg_exc_cause_o,
    output csr_req_o, csr_we_o, csr_addr_o, csr_wdata_o,
    input  csr_rdata_i, csr_ready_i
  );

  modport master (
    output core_req_i, core_we_i, core_addr_i, core_wdata_i,
    input  core_gnt_o, core_rvalid_o, core_rdata_o, core_exc_valid_o, core_exc_cause_o,
    output dbg_req_i, dbg_we_i, dbg_addr_i, dbg_wdata_i,
    input  dbg_gnt_o, dbg_rvalid_o, dbg_rdata_o, dbg_exc_valid_o, dbg_exc_cause_o,
    input  csr_req_o, csr_we_o, csr_addr_o, csr_wdata_o,
    output csr_rdata_i, csr_ready_i
  );
endinterface

// File: rtl/csr_access_arbiter.sv
// Two-port (core/debug) CSR access arbiter with privilege/read-only checks and regfile timeout.
// Define CSR_ACC_VIOL_CNT_EN to build the saturating violation counter behind viol_cnt_o.
module csr_access_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter logic [63:0] ILLEGAL_CAUSE  = 64'd2,
  parameter logic [63:0] TIMEOUT_CAUSE  = 64'd5
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 debug_mode_i,
  csr_access_arbiter_if.slave  bus,
  output logic [15:0]          viol_cnt_o,
  output logic [1:0]           state_o
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_e;

  localparam logic [31:0] TMO = 32'(TIMEOUT_CYCLES);

  state_e      state_q, state_d;
  logic        owner_q, owner_d;        // 1 = debug port owns the access
  logic        prio_dbg_q, prio_dbg_d;  // 1 = debug wins the next contested grant
  logic        we_q, we_d;
  logic [11:0] addr_q, addr_d;
  logic [63:0] wdata_q, wdata_d;
  logic [31:0] tmo_cnt_q, tmo_cnt_d;
  logic [63:0] rdata_q, rdata_d;
  logic        exc_q, exc_d;
  logic [63:0] cause_q, cause_d;

  logic        win_dbg;
  logic        w_we;
  logic [11:0] w_addr;
  logic [63:0] w_wdata;
  logic        w_viol;
  logic        grant;

  // Winner selection and checks are evaluated on whoever would win this IDLE cycle.
  always_comb begin
    win_dbg = bus.dbg_req_i & (~bus.core_req_i | prio_dbg_q);
    w_we    = win_dbg ? bus.dbg_we_i    : bus.core_we_i;
    w_addr  = win_dbg ? bus.dbg_addr_i  : bus.core_addr_i;
    w_wdata = win_dbg ? bus.dbg_wdata_i : bus.core_wdata_i;
    w_viol  = ((w_addr[11:4] == 8'h7B) & ~(win_dbg | debug_mode_i)) |
              (w_we & (w_addr[11:10] == 2'b11));
    grant   = (state_q == S_IDLE) & (bus.core_req_i | bus.dbg_req_i) & ~rst_i;
  end

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    prio_dbg_d = prio_dbg_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    tmo_cnt_d  = tmo_cnt_q;
    rdata_d    = rdata_q;
    exc_d      = exc_q;
    cause_d    = cause_q;
    unique case (state_q)
      S_IDLE: begin
        if (grant) begin
          owner_d    = win_dbg;
          prio_dbg_d = ~win_dbg;
          we_d       = w_we;
          addr_d     = w_addr;
          wdata_d    = w_wdata;
          tmo_cnt_d  = '0;
          rdata_d    = '0;
          if (w_viol) begin
            exc_d   = 1'b1;
            cause_d = ILLEGAL_CAUSE;
            state_d = S_RESP;
          end else begin
            exc_d   = 1'b0;
            cause_d = '0;
            state_d = S_ACCESS;
          end
        end
      end
      S_ACCESS: begin
        // Ready takes precedence over a timeout expiring in the same cycle.
        if (bus.csr_ready_i) begin
          rdata_d = we_q ? 64'd0 : bus.csr_rdata_i;
          exc_d   = 1'b0;
          cause_d = '0;
          state_d = S_RESP;
        end else if ((TMO != 32'd0) && (tmo_cnt_q == TMO - 32'd1)) begin
          rdata_d = '0;
          exc_d   = 1'b1;
          cause_d = TIMEOUT_CAUSE;
          state_d = S_RESP;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 32'd1;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      owner_q    <= 1'b0;
      prio_dbg_q <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      tmo_cnt_q  <= '0;
      rdata_q    <= '0;
      exc_q      <= 1'b0;
      cause_q    <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      prio_dbg_q <= prio_dbg_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      tmo_cnt_q  <= tmo_cnt_d;
      rdata_q    <= rdata_d;
      exc_q      <= exc_d;
      cause_q    <= cause_d;
    end
  end

  logic in_access;
  logic in_resp;
  assign in_access = (state_q == S_ACCESS);
  assign in_resp   = (state_q == S_RESP);
  assign state_o   = state_q;

  assign bus.core_gnt_o = grant & ~win_dbg;
  assign bus.dbg_gnt_o  = grant &  win_dbg;

  assign bus.csr_req_o   = in_access;
  assign bus.csr_we_o    = in_access & we_q;
  assign bus.csr_addr_o  = in_access ? addr_q  : 12'd0;
  assign bus.csr_wdata_o = in_access ? wdata_q : 64'd0;

  // Response fields are forced to zero on the non-owning port.
  assign bus.core_rvalid_o    = in_resp & ~owner_q;
  assign bus.core_rdata_o     = bus.core_rvalid_o ? rdata_q : 64'd0;
  assign bus.core_exc_valid_o = bus.core_rvalid_o & exc_q;
  assign bus.core_exc_cause_o = bus.core_rvalid_o ? cause_q : 64'd0;
  assign bus.dbg_rvalid_o     = in_resp & owner_q;
  assign bus.dbg_rdata_o      = bus.dbg_rvalid_o ? rdata_q : 64'd0;
  assign bus.dbg_exc_valid_o  = bus.dbg_rvalid_o & exc_q;
  assign bus.dbg_exc_cause_o  = bus.dbg_rvalid_o ? cause_q : 64'd0;

`ifdef CSR_ACC_VIOL_CNT_EN
  logic [15:0] viol_cnt_q;
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      viol_cnt_q <= '0;
    end else if (grant && w_viol && (viol_cnt_q != 16'hFFFF)) begin
      viol_cnt_q <= viol_cnt_q + 16'd1;
    end
  end
  assign viol_cnt_o = viol_cnt_q;
`else
  assign viol_cnt_o = 16'd0;
`endif

endmodule

// File: tb/tb_csr_access_arbiter.sv
// Self-checking bench for csr_access_arbiter: directed steps followed by randomized transactions
// checked against a transaction-level model of the arbitration and protection rules.
module tb_csr_access_arbiter;
  localparam int unsigned TMO = 16;

  logic        clk;
  logic        rst;
  logic        debug_mode;
  logic [15:0] viol_cnt;
  logic [1:0]  fsm_state;

  csr_access_arbiter_if bus();

  csr_access_arbiter #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .debug_mode_i(debug_mode),
    .bus         (bus.slave),
    .viol_cnt_o  (viol_cnt),
    .state_o     (fsm_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scoreboard
  int          chk_cnt  = 0;
  int          pass_cnt = 0;
  int          exp_viol = 0;
  int          last_port = 1;           // after reset the core wins a contested grant
  logic [129:0] exp_q[$];               // {owner, exc, cause[63:0], rdata[63:0]}

  // pending requests per port (0 = core, 1 = dbg)
  bit          pend   [2];
  bit          p_we   [2];
  logic [11:0] p_addr [2];
  logic [63:0] p_wdata[2];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    chk_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [15:0] exp_viol_cnt();
`ifdef CSR_ACC_VIOL_CNT_EN
    return (exp_viol > 65535) ? 16'hFFFF : 16'(exp_viol);
`else
    return 16'd0;
`endif
  endfunction

  task automatic load(input int port, input bit we, input logic [11:0] addr, input logic [63:0] wd);
    pend[port]    = 1'b1;
    p_we[port]    = we;
    p_addr[port]  = addr;
    p_wdata[port] = wd;
  endtask

  task automatic apply_reqs();
    bus.core_req_i   = pend[0];
    bus.core_we_i    = p_we[0];
    bus.core_addr_i  = p_addr[0];
    bus.core_wdata_i = p_wdata[0];
    bus.dbg_req_i    = pend[1];
    bus.dbg_we_i     = p_we[1];
    bus.dbg_addr_i   = p_addr[1];
    bus.dbg_wdata_i  = p_wdata[1];
  endtask

  // One full transaction: grant in IDLE, regfile phase (if legal), response check.
  task automatic run_txn(input int rdy_delay, input bit dm_grant, input bit dm_wiggle);
    int           win;
    bit           viol;
    int           n_acc;
    logic [63:0]  rf;
    logic [129:0] e;
    @(negedge clk);
    apply_reqs();
    debug_mode      = dm_grant;
    bus.csr_ready_i = 1'b0;
    #1;
    if (pend[0] && pend[1]) win = (last_port == 0) ? 1 : 0;
    else                    win = pend[1] ? 1 : 0;
    chk("gnt_core", bus.core_gnt_o, 64'(win == 0));
    chk("gnt_dbg", bus.dbg_gnt_o, 64'(win == 1));
    chk("idle_rvalid", {bus.core_rvalid_o, bus.dbg_rvalid_o}, 0);
    viol = ((p_addr[win][11:4] == 8'h7B) && !(win == 1 || dm_grant)) ||
           (p_we[win] && (p_addr[win][11:10] == 2'b11));
    rf    = {$urandom, $urandom};
    n_acc = (rdy_delay < int'(TMO)) ? rdy_delay + 1 : int'(TMO);
    if (viol) begin
      e = {1'(win), 1'b1, 64'd2, 64'd0};
      exp_viol++;
    end else if (rdy_delay < int'(TMO)) begin
      e = {1'(win), 1'b0, 64'd0, (p_we[win] ? 64'd0 : rf)};
    end else begin
      e = {1'(win), 1'b1, 64'd5, 64'd0};
    end
    exp_q.push_back(e);
    last_port = win;
    pend[win] = 1'b0;
    if (!viol) begin
      for (int k = 0; k < n_acc; k++) begin
        @(negedge clk);
        apply_reqs();
        if (dm_wiggle) debug_mode = 1'($urandom);
        bus.csr_ready_i = (k == rdy_delay);
        bus.csr_rdata_i = (k == rdy_delay) ? rf : {$urandom, $urandom};
        #1;
        chk("acc_csr_req", bus.csr_req_o, 1);
        chk("acc_gnt", {bus.core_gnt_o, bus.dbg_gnt_o}, 0);
        chk("acc_rvalid", {bus.core_rvalid_o, bus.dbg_rvalid_o}, 0);
        if (k == 0) begin
          chk("acc_addr", bus.csr_addr_o, 64'(p_addr[win]));
          chk("acc_we", bus.csr_we_o, 64'(p_we[win]));
          chk("acc_wdata", bus.csr_wdata_o, p_wdata[win]);
        end
      end
    end
    @(negedge clk);
    apply_reqs();
    bus.csr_ready_i = 1'b0;
    #1;
    e = exp_q.pop_front();
    chk("resp_csr_req", bus.csr_req_o, 0);
    chk("resp_gnt", {bus.core_gnt_o, bus.dbg_gnt_o}, 0);
    chk("core_rvalid", bus.core_rvalid_o, 64'(e[129] == 1'b0));
    chk("dbg_rvalid", bus.dbg_rvalid_o, 64'(e[129] == 1'b1));
    chk("core_rdata", bus.core_rdata_o, e[129] ? 64'd0 : e[63:0]);
    chk("dbg_rdata", bus.dbg_rdata_o, e[129] ? e[63:0] : 64'd0);
    chk("core_exc", bus.core_exc_valid_o, 64'(!e[129] && e[128]));
    chk("dbg_exc", bus.dbg_exc_valid_o, 64'(e[129] && e[128]));
    chk("core_cause", bus.core_exc_cause_o, e[129] ? 64'd0 : e[127:64]);
    chk("dbg_cause", bus.dbg_exc_cause_o, e[129] ? e[127:64] : 64'd0);
    chk("viol_cnt", viol_cnt, 64'(exp_viol_cnt()));
  endtask

  task automatic check_quiet(input string tag);
    chk({tag, "_csr_req"}, bus.csr_req_o, 0);
    chk({tag, "_gnt"}, {bus.core_gnt_o, bus.dbg_gnt_o}, 0);
    chk({tag, "_rvalid"}, {bus.core_rvalid_o, bus.dbg_rvalid_o}, 0);
    chk({tag, "_exc"}, {bus.core_exc_valid_o, bus.dbg_exc_valid_o}, 0);
    chk({tag, "_viol_cnt"}, viol_cnt, 0);
  endtask

  initial begin
    logic [11:0] ra;
    pend[0] = 0; pend[1] = 0;
    p_we[0] = 0; p_we[1] = 0;
    p_addr[0] = '0; p_addr[1] = '0;
    p_wdata[0] = '0; p_wdata[1] = '0;
    rst = 1'b1;
    debug_mode = 1'b0;
    bus.csr_ready_i = 1'b0;
    bus.csr_rdata_i = '0;
    apply_reqs();
    bus.core_req_i = 1'b1;   // a request during reset must not be granted
    repeat (2) @(negedge clk);
    #1;
    check_quiet("reset");
    @(negedge clk);
    bus.core_req_i = 1'b0;
    rst = 1'b0;

    // legal core read, immediate ready
    load(0, 0, 12'h300, 64'd0);
    run_txn(0, 0, 0);
    // debug window without privilege -> illegal
    load(0, 0, 12'h7B0, 64'd0);
    run_txn(0, 0, 0);
    // debug window with debug_mode, and from the dbg port
    load(0, 0, 12'h7B1, 64'd0);
    run_txn(0, 1, 0);
    load(1, 0, 12'h7B2, 64'd0);
    run_txn(0, 0, 0);
    // read-only space: write denied, read allowed
    load(0, 1, 12'hC00, 64'h1234_5678_9ABC_DEF0);
    run_txn(0, 0, 0);
    load(0, 0, 12'hC00, 64'd0);
    run_txn(2, 0, 0);
    // legal write reaches the regfile, rdata returns 0
    load(1, 1, 12'h305, 64'hDEAD_BEEF_0000_0001);
    run_txn(1, 0, 0);
    // continuous contention: grants alternate
    for (int i = 0; i < 6; i++) begin
      if (!pend[0]) load(0, 0, 12'h340 + 12'(i), 64'd0);
      if (!pend[1]) load(1, 1, 12'h7B0 + 12'(i), {$urandom, $urandom});
      run_txn(0, 0, 0);
    end
    while (pend[0] || pend[1]) run_txn(0, 0, 0);
    // debug_mode dropped mid-flight does not revoke the access
    load(0, 0, 12'h7B3, 64'd0);
    run_txn(3, 1, 1);
    // timeout, and ready on the expiry cycle
    load(0, 0, 12'h300, 64'd0);
    run_txn(99, 0, 0);
    load(1, 0, 12'h301, 64'd0);
    run_txn(int'(TMO) - 1, 0, 0);

    // reset in the middle of an access
    load(0, 0, 12'h302, 64'd0);
    @(negedge clk);
    apply_reqs();
    #1;
    chk("rst_pre_gnt", bus.core_gnt_o, 1);
    pend[0] = 0;
    repeat (3) begin
      @(negedge clk);
      apply_reqs();
      #1;
      chk("rst_pre_acc", bus.csr_req_o, 1);
    end
    @(negedge clk);
    load(1, 0, 12'h303, 64'd0);
    apply_reqs();
    rst = 1'b1;
    #1;
    check_quiet("rst_mid");
    exp_viol  = 0;
    last_port = 1;
    @(negedge clk);
    bus.core_req_i = 1'b0;
    bus.dbg_req_i  = 1'b0;
    rst = 1'b0;
    #1;
    check_quiet("rst_after");
    load(0, 0, 12'h304, 64'd0);
    run_txn(0, 0, 0);       // core wins despite dbg pending
    run_txn(0, 0, 0);

    // randomized traffic
    for (int i = 0; i < 40; i++) begin
      for (int p = 0; p < 2; p++) begin
        if (!pend[p] && ($urandom_range(0, 3) != 0)) begin
          case ($urandom_range(0, 2))
            0:       ra = {8'h7B, 4'($urandom_range(0, 15))};
            1:       ra = {2'b11, 10'($urandom)};
            default: ra = 12'($urandom);
          endcase
          load(p, 1'($urandom), ra, {$urandom, $urandom});
        end
      end
      if (!pend[0] && !pend[1]) load(0, 0, 12'($urandom), 64'd0);
      run_txn($urandom_range(0, 20), 1'($urandom), 1'b1);
    end
    while (pend[0] || pend[1]) run_txn($urandom_range(0, 4), 1'($urandom), 1'b1);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
